// File: rtl/down_timer.sv
`default_nettype none
// ============================================================================
//  Module   : down_timer
//  Purpose  : Loadable down-counter/timer. Counts a programmed value down to
//             terminal count, emits a one-cycle terminal-count pulse, and
//             either raises a sticky done flag (one-shot) or reloads the
//             programmed value and keeps running (periodic).
//
//  Ports    : clk          - clock, all state changes on rising edge
//             rst          - asynchronous active-high reset
//             load         - load cnt_in into counter and reload register
//             enab         - decrement enable (only honoured while running)
//             reload_mode  - 0 one-shot, 1 periodic; sampled at terminal event
//             clr_done     - clear sticky done and return to idle
//             cnt_in       - load value
//             cnt_out      - current count (registered)
//             tc           - terminal-count pulse, one cycle (registered)
//             busy         - high while running (registered)
//             done         - sticky one-shot expiry flag (registered)
//
//  Revision : 1.0 - initial release
// ============================================================================
module down_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enab,
    input  logic             reload_mode,
    input  logic             clr_done,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] cnt_out,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_RUN  = 2'd1;
    localparam logic [1:0] C_DONE = 2'd2;

    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_rld;
    logic             r_tc;
    logic             r_busy;
    logic             r_done;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_rld_nxt;
    logic             w_tc_nxt;
    logic             w_done_nxt;
    logic             w_terminal;
    logic             w_load_nonzero;

    // The terminal event is the 1 -> 0 step while running and enabled. It is
    // the only way the count can reach zero, so decrement never wraps.
    assign w_terminal     = (r_state == C_RUN) && enab && (r_cnt == C_ONE);
    assign w_load_nonzero = (cnt_in != C_ZERO);

    always_comb begin
        // Defaults: hold everything; tc is a pulse so it drops unless set.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rld_nxt   = r_rld;
        w_tc_nxt    = 1'b0;
        w_done_nxt  = r_done;

        if (load) begin
            // Load outranks clr_done, enab and any coincident terminal event.
            w_cnt_nxt   = cnt_in;
            w_rld_nxt   = cnt_in;
            w_done_nxt  = 1'b0;
            w_state_nxt = w_load_nonzero ? C_RUN : C_IDLE;
        end else begin
            case (r_state)
                C_IDLE: begin
                    // Idle holds; enab and clr_done have no effect here.
                    w_state_nxt = C_IDLE;
                end

                C_RUN: begin
                    if (w_terminal) begin
                        w_tc_nxt = 1'b1;
                        if (reload_mode) begin
                            w_cnt_nxt = r_rld;
                        end else begin
                            w_cnt_nxt   = C_ZERO;
                            w_done_nxt  = 1'b1;
                            w_state_nxt = C_DONE;
                        end
                    end else if (enab && (r_cnt > C_ONE)) begin
                        w_cnt_nxt = r_cnt - C_ONE;
                    end
                end

                C_DONE: begin
                    if (clr_done) begin
                        w_done_nxt  = 1'b0;
                        w_state_nxt = C_IDLE;
                    end
                end

                default: begin
                    // Unreachable encoding: recover to a safe idle state.
                    w_state_nxt = C_IDLE;
                    w_cnt_nxt   = C_ZERO;
                    w_done_nxt  = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= C_IDLE;
            r_cnt   <= C_ZERO;
            r_rld   <= C_ZERO;
            r_tc    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rld   <= w_rld_nxt;
            r_tc    <= w_tc_nxt;
            // busy is registered alongside the state so it tracks RUN exactly.
            r_busy  <= (w_state_nxt == C_RUN);
            r_done  <= w_done_nxt;
        end
    end

    assign cnt_out = r_cnt;
    assign tc      = r_tc;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_down_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_down_timer
//  Purpose  : Self-checking bench for down_timer (WIDTH=5). Directed vector
//             table plus hand-written sequences for long counts, load at the
//             terminal edge and asynchronous reset mid-count.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_down_timer;

    localparam int WIDTH = 5;

    logic             clk;
    logic             rst;
    logic             load;
    logic             enab;
    logic             reload_mode;
    logic             clr_done;
    logic [WIDTH-1:0] cnt_in;
    logic [WIDTH-1:0] cnt_out;
    logic             tc;
    logic             busy;
    logic             done;

    int n_cmp;
    int n_err;

    down_timer #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .enab        (enab),
        .reload_mode (reload_mode),
        .clr_done    (clr_done),
        .cnt_in      (cnt_in),
        .cnt_out     (cnt_out),
        .tc          (tc),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             ld;
        logic             en;
        logic             rm;
        logic             cd;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] e_cnt;
        logic             e_tc;
        logic             e_busy;
        logic             e_done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ld, input logic en, input logic rm, input logic cd,
                       input int din, input int e_cnt, input logic e_tc,
                       input logic e_busy, input logic e_done);
        vec_t v;
        v.ld = ld; v.en = en; v.rm = rm; v.cd = cd;
        v.din = WIDTH'(din);
        v.e_cnt = WIDTH'(e_cnt);
        v.e_tc = e_tc; v.e_busy = e_busy; v.e_done = e_done;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input int e_cnt,
                           input logic e_tc, input logic e_busy, input logic e_done);
        chk({tag, ".cnt"},  idx, int'(cnt_out), e_cnt);
        chk({tag, ".tc"},   idx, int'(tc),      int'(e_tc));
        chk({tag, ".busy"}, idx, int'(busy),    int'(e_busy));
        chk({tag, ".done"}, idx, int'(done),    int'(e_done));
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic drive(input logic ld, input logic en, input logic rm,
                         input logic cd, input int din);
        @(negedge clk);
        load = ld; enab = en; reload_mode = rm; clr_done = cd;
        cnt_in = WIDTH'(din);
        @(posedge clk);
        #1;
    endtask

    int seq_b[10] = '{2, 1, 3, 2, 1, 3, 2, 1, 3, 2};
    int seq_c_en[6]  = '{1, 0, 0, 1, 1, 1};
    int seq_c_cnt[6] = '{3, 3, 3, 2, 1, 0};

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; load = 1'b0; enab = 1'b0; reload_mode = 1'b0;
        clr_done = 1'b0; cnt_in = '0;

        // ---------------- vector table ----------------
        // One-shot 5: 5,4,3,2,1,0 with tc/done at 0, then clr_done.
        add(1, 1, 0, 0, 5, 5, 0, 1, 0);
        for (int c = 4; c >= 1; c--) add(0, 1, 0, 0, 0, c, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 1, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 1);   // DONE ignores enab, tc only one cycle
        add(0, 1, 0, 1, 0, 0, 0, 0, 0);   // clr_done -> IDLE
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);   // IDLE ignores enab
        // Periodic 3 for 10 cycles.
        add(1, 1, 1, 0, 3, 3, 0, 1, 0);
        for (int i = 0; i < 10; i++) add(0, 1, 1, 0, 0, seq_b[i], seq_b[i] == 3, 1, 0);
        // Load 4 one-shot, enab gaps stretch by two cycles.
        add(1, 0, 0, 0, 4, 4, 0, 1, 0);
        for (int i = 0; i < 6; i++)
            add(0, seq_c_en[i][0], 0, 0, 0, seq_c_cnt[i], i == 5, i != 5, i == 5);
        // load + clr_done together in DONE: load wins.
        add(1, 0, 0, 1, 2, 2, 0, 1, 0);
        add(0, 0, 0, 1, 0, 2, 0, 1, 0);   // clr_done in RUN: no effect
        add(0, 1, 0, 0, 0, 1, 0, 1, 0);
        add(0, 1, 1, 0, 0, 2, 1, 1, 0);   // reload_mode sampled at terminal: reload
        add(0, 1, 0, 0, 0, 1, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 1, 0, 1);   // now one-shot at terminal
        // Load 0: stays idle under enab.
        add(1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0, 0);
        // Periodic N=1: tc every cycle.
        add(1, 1, 1, 0, 1, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0, 1, 1, 1, 0);

        // ---------------- reset state ----------------
        #2;
        chk_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].ld, vecs[i].en, vecs[i].rm, vecs[i].cd, int'(vecs[i].din));
            chk_all("vec", i, int'(vecs[i].e_cnt), vecs[i].e_tc, vecs[i].e_busy, vecs[i].e_done);
        end

        // ---------------- max value one-shot ----------------
        drive(1, 1, 0, 0, 31);
        chk_all("max_load", 0, 31, 0, 1, 0);
        for (int i = 1; i <= 31; i++) begin
            drive(0, 1, 0, 0, 0);
            chk_all("max_run", i, 31 - i, i == 31, i != 31, i == 31);
        end
        drive(0, 1, 0, 0, 0);
        chk_all("max_after", 0, 0, 0, 0, 1);

        // ---------------- load coincident with terminal ----------------
        drive(1, 1, 0, 0, 31);
        for (int i = 1; i <= 30; i++) drive(0, 1, 0, 0, 0);
        chk_all("pre_term", 0, 1, 0, 1, 0);
        drive(1, 1, 0, 0, 6);
        chk_all("load_at_term", 0, 6, 0, 1, 0);
        drive(0, 1, 0, 0, 0);
        chk_all("after_load_term", 0, 5, 0, 1, 0);

        // ---------------- async reset mid-count ----------------
        drive(1, 1, 0, 0, 9);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        chk_all("pre_rst", 0, 7, 0, 1, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        load = 1'b1; cnt_in = WIDTH'(3); enab = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_rst_load", 0, 3, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/down_timer.md
# down_timer

Loadable down-counter/timer that counts a programmed value down to terminal count and reports expiry. It complements the team's loadable up-counter: the same load/enable control style, but counting in the other direction, with a terminal-count pulse, a sticky done flag and an optional periodic auto-reload. It sits beside the up-counter in timing and control paths, for timeouts, delays and periodic ticks.

## Interface

- `WIDTH`, default 5: width of the count, load value and reload register.

- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  reset; asynchronous, active-high.
- `load`  input  1  load `cnt_in` into the counter and the reload register, then start.
- `enab`  input  1  decrement enable; counts only while in RUN.
- `reload_mode`  input  1  0 = one-shot, 1 = periodic auto-reload; sampled at the terminal event.
- `clr_done`  input  1  clear the sticky `done` flag and return to IDLE.
- `cnt_in`  input  WIDTH  load value.
- `cnt_out`  output  WIDTH  current count, registered.
- `tc`  output  1  terminal-count pulse, one cycle, registered.
- `busy`  output  1  high while in RUN, registered.
- `done`  output  1  sticky expiry flag in one-shot mode, registered.

## Operation

- Internal state:
  - FSM with states IDLE, RUN, DONE.
  - Reload register `rld`, WIDTH bits.
- Reset (async, any time, including mid-count):
  - `cnt_out`=0, `rld`=0, state=IDLE.
  - `tc`=0, `busy`=0, `done`=0.
- Priority, highest first: `rst`, `load`, `clr_done`, `enab`.
- `load`=1, in any state:
  - `cnt_out`<=`cnt_in` and `rld`<=`cnt_in`; `done`<=0, `tc`<=0.
  - If `cnt_in`≠0, go to RUN.
  - If `cnt_in`=0, go to IDLE, with no `tc` and no `done`.
- IDLE: everything holds; `enab` is ignored.
- RUN, `enab`=0: `cnt_out` holds and `tc`=0.
- RUN, `enab`=1, `cnt_out`>1: `cnt_out`<=`cnt_out`-1 and `tc`<=0.
- RUN, `enab`=1, `cnt_out`=1 (terminal event), with `tc`<=1 in both modes:
  - `reload_mode`=1: `cnt_out`<=`rld` and stay in RUN.
  - `reload_mode`=0: `cnt_out`<=0, `done`<=1, go to DONE.
- DONE:
  - `cnt_out` holds 0, `done` holds 1, `enab` is ignored.
  - `clr_done`=1 moves to IDLE with `done`<=0.
- `clr_done` in IDLE or RUN: no effect on state or count; `done` is already 0.
- Arithmetic and range:
  - Unsigned.
  - Decrement never wraps; the 1 to 0 step is the only path to zero.
  - Load values 1 to 2^WIDTH-1 are valid.
- `busy` is 1 exactly while the state is RUN.

## Timing

- Load to first decrement:
  - `load` sampled at edge k gives `cnt_out`=`cnt_in` and `busy`=1 after edge k.
  - With `enab` held at 1, the first decrement happens at edge k+1.
- One-shot timing, load value N≥1 with `enab` continuously 1:
  - `cnt_out` reaches 0, and `tc` and `done` rise, N edges after the load edge.
  - `tc` is high for exactly one cycle.
- Periodic timing, load value N with `enab` continuously 1:
  - `tc` fires every N cycles; N=1 gives `tc` high every cycle.
- `enab` gaps stretch the interval by exactly the number of cycles `enab` is low.
- `reload_mode` change mid-count takes effect at the next terminal event only.
- `load` coincident with a terminal event: the load wins and `tc` stays 0.
- `clr_done` coincident with `load`: the load wins; result is RUN (or IDLE if `cnt_in`=0) with `done`=0.
- `rst` asserted mid-operation: all outputs go to 0 without waiting for a clock edge. The first load is accepted at the first edge after `rst` deasserts.

## Test plan

- Reset, then `load`, `cnt_in`=5, `reload_mode`=0, `enab`=1 throughout:
  - `cnt_out` goes 5,4,3,2,1,0.
  - `tc` is high one cycle as `cnt_out` becomes 0; `done` goes to 1; `busy` goes 1 then 0.
  - `clr_done` then returns `done` to 0.
- Load 3 with `reload_mode`=1 and `enab`=1 for 10 cycles:
  - `cnt_out` goes 3,2,1,3,2,1,3,...
  - `tc` pulses every 3 cycles; `done` stays 0.
- Load 4, then toggle `enab` 1,0,0,1,1,1:
  - Count holds while `enab` is low; `tc` arrives 2 cycles later than with continuous enable.
- Load 31 (max for WIDTH=5), run one-shot:
  - `tc` comes 31 cycles after load and `cnt_out` ends at 0 (no wrap).
  - Repeat with `load` at the same edge as `cnt_out`=1: new value loads and no `tc`.
- Edge cases:
  - Load `cnt_in`=0: state stays IDLE; `tc`, `done` and `busy` stay 0 under `enab`=1.
  - Assert `rst` while `cnt_out`=7 in RUN: all outputs go to 0 immediately, before the next clock edge.
